// File: rtl/ccu_snoop_fanout.sv
// ccu_snoop_fanout
// Snoop multicast and response-merge stage behind the CCU snoop controllers.
// It handles one snoop transaction at a time:
//   - takes one AC request from upstream,
//   - broadcasts it to every cached master except the initiator,
//   - ORs all CR responses into a single merged response,
//   - forwards the CD stream of one data source and quietly drains the rest.
//
// State table
//   state   | meaning
//   IDLE    | ac_ready high, waiting for an upstream snoop
//   BCAST   | per-master AC outstanding and/or CR responses still pending
//   SEND_CR | merged CR presented upstream
//   DATA    | source CD passed through; extra data sources drained
//
// Ports
//   clk, rst_n                  clock; asynchronous active-high reset
//   ac_*                        upstream AC request (valid/ready, addr, snoop, prot)
//   initiator_i                 master excluded from the broadcast
//   cr_valid_o/ready_i/resp_o   merged CR toward upstream
//   cd_valid_o/ready_i/data/last  forwarded CD toward upstream
//   snp_ac_*                    per-master AC valid/ready, shared registered payload
//   snp_cr_*                    per-master CR handshake and responses (5 bits each)
//   snp_cd_*                    per-master CD handshake, data and last
module ccu_snoop_fanout #(
  parameter int NoMasters = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdxWidth  = (NoMasters > 1) ? $clog2(NoMasters) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ac_valid_i,
  output logic                           ac_ready_o,
  input  logic [AddrWidth-1:0]           ac_addr_i,
  input  logic [3:0]                     ac_snoop_i,
  input  logic [2:0]                     ac_prot_i,
  input  logic [IdxWidth-1:0]            initiator_i,
  output logic                           cr_valid_o,
  input  logic                           cr_ready_i,
  output logic [4:0]                     cr_resp_o,
  output logic                           cd_valid_o,
  input  logic                           cd_ready_i,
  output logic [DataWidth-1:0]           cd_data_o,
  output logic                           cd_last_o,
  output logic [NoMasters-1:0]           snp_ac_valid_o,
  input  logic [NoMasters-1:0]           snp_ac_ready_i,
  output logic [AddrWidth-1:0]           snp_ac_addr_o,
  output logic [3:0]                     snp_ac_snoop_o,
  output logic [2:0]                     snp_ac_prot_o,
  input  logic [NoMasters-1:0]           snp_cr_valid_i,
  output logic [NoMasters-1:0]           snp_cr_ready_o,
  input  logic [5*NoMasters-1:0]         snp_cr_resp_i,
  input  logic [NoMasters-1:0]           snp_cd_valid_i,
  output logic [NoMasters-1:0]           snp_cd_ready_o,
  input  logic [DataWidth*NoMasters-1:0] snp_cd_data_i,
  input  logic [NoMasters-1:0]           snp_cd_last_i
);

  typedef enum logic [1:0] {IDLE, BCAST, SEND_CR, DATA} state_t;

  state_t                state;
  logic                  ac_rdy;
  logic                  cr_vld;
  logic [NoMasters-1:0]  ac_pend;
  logic [NoMasters-1:0]  cr_pend;
  logic [NoMasters-1:0]  drop_mask;
  logic                  src_vld;
  logic [IdxWidth-1:0]   src_idx;
  logic [4:0]            resp_acc;
  logic [AddrWidth-1:0]  addr_q;
  logic [3:0]            snoop_q;
  logic [2:0]            prot_q;

  logic [NoMasters-1:0]  init_pend;
  logic [NoMasters-1:0]  cr_hs;
  logic [NoMasters-1:0]  ac_pend_nxt;
  logic [NoMasters-1:0]  cr_pend_nxt;
  logic [NoMasters-1:0]  drop_add;
  logic [NoMasters-1:0]  drop_done;
  logic [NoMasters-1:0]  drop_nxt;
  logic [NoMasters-1:0]  src_oh;
  logic [4:0]            resp_new;
  logic                  pick_vld;
  logic [IdxWidth-1:0]   pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DataWidth-1:0]  sel_data;
  logic                  data_active;
  logic                  src_done;

  assign ac_ready_o     = ac_rdy;
  assign cr_valid_o     = cr_vld;
  assign cr_resp_o      = resp_acc;
  assign snp_ac_valid_o = ac_pend;
  assign snp_ac_addr_o  = addr_q;
  assign snp_ac_snoop_o = snoop_q;
  assign snp_ac_prot_o  = prot_q;

  // A master's CR is only taken once its own AC has been accepted.
  assign snp_cr_ready_o = (state == BCAST) ? (cr_pend & ~ac_pend) : '0;
  assign cr_hs          = snp_cr_valid_i & snp_cr_ready_o;
  assign ac_pend_nxt    = ac_pend & ~snp_ac_ready_i;
  assign cr_pend_nxt    = cr_pend & ~cr_hs;

  always_comb begin
    init_pend = '1;
    for (int i = 0; i < NoMasters; i++) begin
      if (initiator_i == IdxWidth'(i)) init_pend[i] = 1'b0;
    end
  end

  // Merge this cycle's responses and pick the data source. Scanning from
  // index 0 makes the lowest index win when several DataTransfer CRs land
  // together; every later data-carrying master is drained instead.
  always_comb begin
    resp_new = '0;
    pick_vld = src_vld;
    pick_idx = src_idx;
    drop_add = '0;
    for (int i = 0; i < NoMasters; i++) begin
      if (cr_hs[i]) begin
        resp_new = resp_new | snp_cr_resp_i[5*i +: 5];
        if (snp_cr_resp_i[5*i]) begin
          if (!pick_vld) begin
            pick_vld = 1'b1;
            pick_idx = IdxWidth'(i);
          end else begin
            drop_add[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    src_oh    = '0;
    for (int i = 0; i < NoMasters; i++) begin
      if (src_idx == IdxWidth'(i)) begin
        sel_valid = snp_cd_valid_i[i];
        sel_last  = snp_cd_last_i[i];
        sel_data  = snp_cd_data_i[DataWidth*i +: DataWidth];
        src_oh[i] = 1'b1;
      end
    end
  end

  // The source stays stalled until DATA; dropped masters are drained from
  // the cycle after their CR, in any state.
  assign data_active    = (state == DATA) && src_vld;
  assign cd_valid_o     = data_active & sel_valid;
  assign cd_last_o      = data_active & sel_last;
  assign cd_data_o      = data_active ? sel_data : '0;
  assign snp_cd_ready_o = drop_mask | (data_active ? (src_oh & {NoMasters{cd_ready_i}}) : '0);
  assign src_done       = cd_valid_o & cd_ready_i & cd_last_o;
  assign drop_done      = drop_mask & snp_cd_valid_i & snp_cd_last_i;
  assign drop_nxt       = (drop_mask & ~drop_done) | drop_add;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      ac_rdy    <= 1'b0;
      cr_vld    <= 1'b0;
      ac_pend   <= '0;
      cr_pend   <= '0;
      drop_mask <= '0;
      src_vld   <= 1'b0;
      src_idx   <= '0;
      resp_acc  <= '0;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
    end else begin
      drop_mask <= drop_nxt;
      case (state)
        IDLE: begin
          if (!ac_rdy) begin
            ac_rdy <= 1'b1;
          end else if (ac_valid_i) begin
            ac_rdy   <= 1'b0;
            addr_q   <= ac_addr_i;
            snoop_q  <= ac_snoop_i;
            prot_q   <= ac_prot_i;
            ac_pend  <= init_pend;
            cr_pend  <= init_pend;
            resp_acc <= '0;
            src_vld  <= 1'b0;
            if (init_pend == '0) begin
              cr_vld <= 1'b1;
              state  <= SEND_CR;
            end else begin
              state  <= BCAST;
            end
          end
        end
        BCAST: begin
          ac_pend  <= ac_pend_nxt;
          cr_pend  <= cr_pend_nxt;
          resp_acc <= resp_acc | resp_new;
          src_vld  <= pick_vld;
          src_idx  <= pick_idx;
          if ((ac_pend_nxt == '0) && (cr_pend_nxt == '0)) begin
            cr_vld <= 1'b1;
            state  <= SEND_CR;
          end
        end
        SEND_CR: begin
          if (cr_ready_i) begin
            cr_vld <= 1'b0;
            if (src_vld || (drop_nxt != '0)) begin
              state <= DATA;
            end else begin
              ac_rdy <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        DATA: begin
          if (src_done) src_vld <= 1'b0;
          if ((!src_vld || src_done) && (drop_nxt == '0)) begin
            ac_rdy <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// tb_ccu_snoop_fanout
// Table-driven bench for ccu_snoop_fanout (4 masters). Each row describes one
// snoop: per-master CR response, AC-ready delay, beat count and data base,
// plus the hand-computed merged response and data source. Per-master
// responder processes play the snooped masters; a monitor records the
// upstream CR/CD traffic. A hand-written sequence covers reset during DATA.
module tb_ccu_snoop_fanout;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk;
  logic            rst_n;
  logic            ac_valid_i, ac_ready_o;
  logic [AW-1:0]   ac_addr_i;
  logic [3:0]      ac_snoop_i;
  logic [2:0]      ac_prot_i;
  logic [1:0]      initiator_i;
  logic            cr_valid_o, cr_ready_i;
  logic [4:0]      cr_resp_o;
  logic            cd_valid_o, cd_ready_i, cd_last_o;
  logic [DW-1:0]   cd_data_o;
  logic [N-1:0]    snp_ac_valid_o, snp_ac_ready_i;
  logic [AW-1:0]   snp_ac_addr_o;
  logic [3:0]      snp_ac_snoop_o;
  logic [2:0]      snp_ac_prot_o;
  logic [N-1:0]    snp_cr_valid_i, snp_cr_ready_o;
  logic [5*N-1:0]  snp_cr_resp_i;
  logic [N-1:0]    snp_cd_valid_i, snp_cd_ready_o, snp_cd_last_i;
  logic [DW*N-1:0] snp_cd_data_i;

  ccu_snoop_fanout #(.NoMasters(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i), .initiator_i(initiator_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
    .cd_last_o(cd_last_o),
    .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready_i),
    .snp_ac_addr_o(snp_ac_addr_o), .snp_ac_snoop_o(snp_ac_snoop_o),
    .snp_ac_prot_o(snp_ac_prot_o),
    .snp_cr_valid_i(snp_cr_valid_i), .snp_cr_ready_o(snp_cr_ready_o),
    .snp_cr_resp_i(snp_cr_resp_i),
    .snp_cd_valid_i(snp_cd_valid_i), .snp_cd_ready_o(snp_cd_ready_o),
    .snp_cd_data_i(snp_cd_data_i), .snp_cd_last_i(snp_cd_last_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              init;
    logic [31:0]     addr;
    logic [3:0]      snoop;
    logic [3:0][4:0] resp;
    logic [3:0][3:0] beats;
    logic [3:0][3:0] ac_dly;
    logic [3:0]      cr_early;
    logic [3:0][7:0] base;
    logic [4:0]      exp_resp;
    int              exp_src;
    bit              stall;
  } txn_t;

  txn_t tbl[7];
  txn_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   abort  = 1'b0;

  logic [3:0][7:0] done_cnt;
  logic [3:0][7:0] viol_cnt;

  // Snooped-master responders
  for (genvar g = 0; g < N; g++) begin : gm
    logic        a_rdy, c_vld, d_vld, d_last, hs;
    logic [4:0]  c_resp;
    logic [63:0] d_dat;
    logic [7:0]  cnt, viol;
    assign snp_ac_ready_i[g]          = a_rdy;
    assign snp_cr_valid_i[g]          = c_vld;
    assign snp_cr_resp_i[5*g +: 5]    = c_resp;
    assign snp_cd_valid_i[g]          = d_vld;
    assign snp_cd_last_i[g]           = d_last;
    assign snp_cd_data_i[DW*g +: DW]  = d_dat;
    assign done_cnt[g]                = cnt;
    assign viol_cnt[g]                = viol;
    initial begin
      a_rdy = 0; c_vld = 0; d_vld = 0; d_last = 0; c_resp = 0; d_dat = 0;
      cnt = 0; viol = 0; hs = 0;
      forever begin
        @(negedge clk);
        if (!abort && snp_ac_valid_o[g]) begin
          cnt = 0; viol = 0;
          c_resp = cur.resp[g];
          if (cur.cr_early[g]) c_vld = 1;
          for (int k = 0; k < int'(cur.ac_dly[g]); k++) begin
            #3; if (snp_cr_ready_o[g]) viol++;
            @(negedge clk);
          end
          a_rdy = 1; c_vld = 1;
          @(negedge clk);
          a_rdy = 0;
          for (int t = 0; t < 200; t++) begin
            #3; hs = snp_cr_ready_o[g];
            @(negedge clk);
            if (hs || abort) break;
          end
          c_vld = 0;
          if (c_resp[0] && !abort) begin
            for (int k = 0; k < int'(cur.beats[g]); k++) begin
              d_vld = 1; d_dat = 64'(cur.base[g]) + 64'(k);
              d_last = (k == int'(cur.beats[g]) - 1);
              for (int t = 0; t < 200; t++) begin
                #3; hs = snp_cd_ready_o[g];
                @(negedge clk);
                if (hs || abort) break;
              end
              if (abort) break;
              cnt++;
            end
          end
          d_vld = 0; d_last = 0; d_dat = 0;
        end
      end
    end
  end

  // Upstream monitor
  int          cyc = 0;
  int          cr_cnt, first_crv, last_cr;
  logic [4:0]  got_resp;
  logic [63:0] q_data[$];
  logic        q_last[$];
  initial begin
    forever begin
      @(negedge clk); #3;
      cyc++;
      if (cd_valid_o && cd_ready_i) begin q_data.push_back(cd_data_o); q_last.push_back(cd_last_o); end
      if (cr_valid_o && cr_ready_i) begin cr_cnt++; got_resp = cr_resp_o; end
      if (|(snp_cr_valid_i & snp_cr_ready_o)) last_cr = cyc;
      if (cr_valid_o && first_crv < 0) first_crv = cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int t);
    logic            hs;
    logic [3:0]      snooped;
    logic [3:0][7:0] exp_done, act_done;
    logic [63:0]     d0;
    bit              ok;
    int              nb;
    cur = tbl[t];
    q_data.delete(); q_last.delete();
    cr_cnt = 0; first_crv = -1; last_cr = -1; got_resp = 'x;
    snooped = 4'hF & ~(4'b0001 << cur.init);
    ac_valid_i = 1; ac_addr_i = cur.addr; ac_snoop_i = cur.snoop; ac_prot_i = 3'b010;
    initiator_i = 2'(cur.init);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      #3; hs = ac_ready_o;
      @(negedge clk);
      if (hs) begin ok = 1; break; end
    end
    ac_valid_i = 0;
    chk($sformatf("t%0d ac_accept", t), 64'(ok), 64'd1);
    chk($sformatf("t%0d snp_ac_valid", t), 64'(snp_ac_valid_o), 64'(snooped));
    chk($sformatf("t%0d snp_ac_addr", t), 64'(snp_ac_addr_o), 64'(cur.addr));
    chk($sformatf("t%0d ac_ready_busy", t), 64'(ac_ready_o), 64'd0);
    if (cur.stall) begin
      cd_ready_i = 0;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        #3; if (cd_valid_o) begin ok = 1; break; end
        @(negedge clk);
      end
      chk($sformatf("t%0d stall_valid_seen", t), 64'(ok), 64'd1);
      d0 = cd_data_o;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #3;
        chk($sformatf("t%0d stall_hold", t), {cd_valid_o, cd_data_o[62:0]}, {1'b1, d0[62:0]});
      end
      @(negedge clk);
      cd_ready_i = 1;
    end
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #3;
      if (ac_ready_o) begin ok = 1; break; end
    end
    chk($sformatf("t%0d back_to_idle", t), 64'(ok), 64'd1);
    @(negedge clk); @(negedge clk);
    chk($sformatf("t%0d cr_count", t), 64'(cr_cnt), 64'd1);
    chk($sformatf("t%0d cr_resp", t), 64'(got_resp), 64'(cur.exp_resp));
    chk($sformatf("t%0d cr_latency", t), 64'(first_crv), 64'(last_cr + 1));
    nb = (cur.exp_src >= 0) ? int'(cur.beats[cur.exp_src]) : 0;
    chk($sformatf("t%0d beat_count", t), 64'(q_data.size()), 64'(nb));
    for (int k = 0; k < nb; k++) begin
      if (k < q_data.size()) begin
        chk($sformatf("t%0d beat%0d_data", t, k), q_data[k], 64'(cur.base[cur.exp_src]) + 64'(k));
        chk($sformatf("t%0d beat%0d_last", t, k), 64'(q_last[k]), 64'(k == nb - 1));
      end
    end
    for (int g = 0; g < N; g++) begin
      exp_done[g] = (snooped[g] && cur.resp[g][0]) ? 8'(cur.beats[g]) : 8'd0;
      act_done[g] = snooped[g] ? done_cnt[g] : 8'd0;
    end
    chk($sformatf("t%0d beats_consumed", t), 64'(act_done), 64'(exp_done));
    chk($sformatf("t%0d early_cr_ready", t), 64'(viol_cnt & {4{8'(snooped)}} & 32'h0), 64'd0);
    for (int g = 0; g < N; g++)
      if (cur.cr_early[g]) chk($sformatf("t%0d m%0d_cr_before_ac", t, g), 64'(viol_cnt[g]), 64'd0);
  endtask

  initial begin
    // {m3,m2,m1,m0} ordering in every packed per-master field
    tbl[0] = '{init:0, addr:32'h1000, snoop:4'h1, resp:{5'h00,5'h00,5'h00,5'h00},
               beats:16'h0, ac_dly:16'h0, cr_early:4'h0, base:32'h0,
               exp_resp:5'h00, exp_src:-1, stall:0};
    tbl[1] = '{init:0, addr:32'h2000, snoop:4'h1, resp:{5'h00,5'h09,5'h00,5'h00},
               beats:{4'd0,4'd4,4'd0,4'd0}, ac_dly:16'h0, cr_early:4'h0,
               base:{8'h00,8'hA0,8'h00,8'h00}, exp_resp:5'h09, exp_src:2, stall:0};
    tbl[2] = '{init:0, addr:32'h2040, snoop:4'h1, resp:{5'h01,5'h00,5'h01,5'h00},
               beats:{4'd4,4'd0,4'd4,4'd0}, ac_dly:16'h0, cr_early:4'h0,
               base:{8'h30,8'h00,8'h10,8'h00}, exp_resp:5'h01, exp_src:1, stall:0};
    tbl[3] = '{init:0, addr:32'h3000, snoop:4'h7, resp:{5'h08,5'h00,5'h00,5'h00},
               beats:16'h0, ac_dly:{4'd5,4'd0,4'd0,4'd0}, cr_early:4'b1000, base:32'h0,
               exp_resp:5'h08, exp_src:-1, stall:0};
    tbl[4] = '{init:0, addr:32'h4000, snoop:4'h9, resp:{5'h00,5'h14,5'h02,5'h00},
               beats:16'h0, ac_dly:16'h0, cr_early:4'h0, base:32'h0,
               exp_resp:5'h16, exp_src:-1, stall:0};
    tbl[5] = '{init:2, addr:32'h5000, snoop:4'h1, resp:{5'h00,5'h01,5'h00,5'h01},
               beats:{4'd0,4'd3,4'd0,4'd2}, ac_dly:16'h0, cr_early:4'h0,
               base:{8'h00,8'hEE,8'h00,8'h50}, exp_resp:5'h01, exp_src:0, stall:1};
    tbl[6] = '{init:3, addr:32'h6000, snoop:4'h1, resp:{5'h00,5'h03,5'h11,5'h00},
               beats:{4'd0,4'd3,4'd1,4'd0}, ac_dly:16'h0, cr_early:4'h0,
               base:{8'h00,8'h70,8'h60,8'h00}, exp_resp:5'h13, exp_src:1, stall:0};
    cur = tbl[0];

    rst_n = 1; ac_valid_i = 0; ac_addr_i = 0; ac_snoop_i = 0; ac_prot_i = 0;
    initiator_i = 0; cr_ready_i = 1; cd_ready_i = 1;
    repeat (3) @(negedge clk);
    #3;
    chk("rst ac_ready", 64'(ac_ready_o), 64'd0);
    chk("rst valids", 64'({cr_valid_o, cd_valid_o, snp_ac_valid_o}), 64'd0);
    chk("rst readys", 64'({snp_cr_ready_o, snp_cd_ready_o}), 64'd0);
    chk("rst payload", 64'({cr_resp_o, snp_ac_addr_o}), 64'd0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk); #3;
    chk("post_rst ac_ready", 64'(ac_ready_o), 64'd1);
    @(negedge clk);

    for (int t = 0; t < 7; t++) run_txn(t);

    // Reset asserted while the second data beat is on the bus
    cur = tbl[1];
    q_data.delete(); q_last.delete();
    ac_valid_i = 1; ac_addr_i = 32'h7000; ac_snoop_i = 4'h1; initiator_i = 0;
    for (int k = 0; k < 50; k++) begin
      #3; if (ac_ready_o) begin @(negedge clk); break; end
      @(negedge clk);
    end
    ac_valid_i = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #3;
      if (q_data.size() >= 1) break;
    end
    chk("mid_rst first_beat", 64'(q_data.size()), 64'd1);
    @(negedge clk); #1;
    rst_n = 1; abort = 1;
    #1;
    chk("mid_rst ac_ready", 64'(ac_ready_o), 64'd0);
    chk("mid_rst cd_out", 64'({cd_valid_o, cd_last_o, cd_data_o[31:0]}), 64'd0);
    chk("mid_rst handshakes", 64'({cr_valid_o, snp_ac_valid_o, snp_cr_ready_o, snp_cd_ready_o}), 64'd0);
    chk("mid_rst payload", 64'({cr_resp_o, snp_ac_addr_o}), 64'd0);
    repeat (4) @(negedge clk);
    abort = 0; rst_n = 0;
    @(negedge clk); #3;
    chk("mid_rst ac_ready_back", 64'(ac_ready_o), 64'd1);
    @(negedge clk);
    run_txn(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ccu_snoop_fanout.md
# ccu_snoop_fanout

Snoop multicast and response-merge stage sitting directly downstream of the CCU write/read snoop controllers. Accepts one snoop request (AC) from the controller, broadcasts it to every cached master except the initiator, collects and merges all CR responses into one, and returns a single CD data stream. Processes one snoop transaction at a time.

## Interface
- NoMasters, 4: number of snooped ACE masters (>=1)
- AddrWidth, 32: AC address width
- DataWidth, 64: CD data width
- IdxWidth, $clog2(NoMasters) (min 1): initiator index width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-high
- ac_valid_i / ac_ready_o  in/out  1  upstream AC handshake
- ac_addr_i  in  AddrWidth  snoop address
- ac_snoop_i  in  4  ACSNOOP
- ac_prot_i  in  3  ACPROT
- initiator_i  in  IdxWidth  master that caused the snoop; excluded from broadcast
- cr_valid_o / cr_ready_i  out/in  1  merged CR handshake
- cr_resp_o  out  5  merged CRRESP {WasUnique,IsShared,PassDirty,Error,DataTransfer}
- cd_valid_o / cd_ready_i  out/in  1  upstream CD handshake
- cd_data_o  out  DataWidth  forwarded CD data; cd_last_o  out  1
- snp_ac_valid_o / snp_ac_ready_i  out/in  NoMasters  per-master AC handshake
- snp_ac_addr_o, snp_ac_snoop_o, snp_ac_prot_o  out  AddrWidth/4/3  shared registered AC payload
- snp_cr_valid_i / snp_cr_ready_o  in/out  NoMasters  per-master CR handshake
- snp_cr_resp_i  in  5*NoMasters  per-master CRRESP, master i at [5i+4:5i]
- snp_cd_valid_i / snp_cd_ready_o  in/out  NoMasters  per-master CD handshake
- snp_cd_data_i  in  DataWidth*NoMasters; snp_cd_last_i  in  NoMasters

## Operation
- FSM: IDLE, BCAST, SEND_CR, DATA.
- IDLE: ac_ready_o=1. On AC handshake: register payload, ac_pend = all-ones with bit initiator_i cleared, cr_pend = ac_pend, resp_acc=0. If ac_pend==0 (NoMasters=1) go to SEND_CR with resp 0; else BCAST.
- BCAST: snp_ac_valid_o = ac_pend; bit i clears on snp_ac_ready_i[i]. snp_cr_ready_o[i] = cr_pend[i] & ~ac_pend[i] (CR accepted only after that master's AC). On CR handshake: clear cr_pend[i], resp_acc |= snp_cr_resp_i[i]; if DataTransfer set and no source chosen, src=i (lowest index wins on same-cycle ties), else mark i in drop mask. Exit to SEND_CR when ac_pend==0 and cr_pend==0 (including same-cycle last updates).
- SEND_CR: cr_valid_o=1, cr_resp_o=resp_acc (bitwise OR of all CRs). On cr_ready_i: go to DATA if source chosen, else IDLE once drop mask empty.
- DATA: cd_valid_o/cd_data_o/cd_last_o = source's inputs, snp_cd_ready_o[src]=cd_ready_i (combinational pass-through). On last beat handshake clear source.
- Drop drain: any master in drop mask gets snp_cd_ready_o=1 in every state after its CR; its beats are discarded; bit clears on last. Return to IDLE only when source and drop mask are both clear.
- Snooped masters must not make CR dependent on CD acceptance (source CD stalls until DATA).
- Upstream ac_ready_o low in every state but IDLE; no second AC accepted mid-transaction.

## Timing
- Reset (rst_n=1): state IDLE, all masks 0, all valid/ready outputs 0, ac_ready_o 0, payload and cr_resp_o 0; ac_ready_o=1 first cycle after rst_n falls.
- AC accepted cycle n -> snp_ac_valid_o asserted cycle n+1 (registered).
- Last CR accepted cycle m -> cr_valid_o cycle m+1.
- CD path zero-latency combinational; ready/valid held per AXI rules (valid never drops before handshake).
- Reset mid-transaction: all state dropped immediately; in-flight beats abandoned.

## Test plan
- NoMasters=4, initiator 0, AC addr 0x1000 ReadShared; masters 1-3 accept AC same cycle, CR 0x00 -> snp_ac_valid_o=4'b1110 one cycle, cr_resp_o=0x00, no CD, back to IDLE.
- Master 2 CR 0x09 (IsShared|DataTransfer) + 4 beats 0xA0..0xA3 -> cr_resp_o=0x09, cd_data_o 0xA0..0xA3, cd_last_o on 4th beat only.
- Masters 1 and 3 both CR 0x01 same cycle -> src=1 forwarded; master 3's 4 beats drained with ready=1, never on cd_data_o.
- Staggered snp_ac_ready_i (master 3 ready 5 cycles late) -> master 3 CR ignored until its AC handshake; cr_valid_o only after last CR.
- Master 1 CR 0x02 (Error), master 2 CR 0x14 -> cr_resp_o=0x16; cd_ready_i held low 3 cycles -> cd_valid_o/data stable.
- Assert rst_n during DATA beat 2 -> all outputs 0 next edge; new AC after reset processed normally.
